// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - single-port frame-buffer BRAM arbiter between Z80 CPU and video fetcher
module fb_port_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 8,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_wait_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int                CNT_W   = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(CPU_MAX_WAIT);

    logic              cpu_armed_q, cpu_armed_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              cpu_ack_we_q, cpu_ack_we_d;
    logic              vid_rvalid_q, vid_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    logic cpu_pend;
    logic vid_slot;
    logic cpu_slot;
    logic cpu_rd_ack;

    // Slot selection: video by default, CPU once it has watched CPU_MAX_WAIT video grants go by.
    always_comb begin
        vid_slot = 1'b0;
        cpu_slot = 1'b0;
        cpu_pend = cpu_req & cpu_armed_q;
        if (reset_n) begin
            if (vid_req && (!cpu_pend || (starve_cnt_q < MAX_CNT))) begin
                vid_slot = 1'b1;
            end else if (cpu_pend) begin
                cpu_slot = 1'b1;
            end
        end
        vid_gnt    = vid_slot;
        ram_en     = vid_slot | cpu_slot;
        ram_we     = cpu_slot & cpu_we;
        ram_addr   = vid_slot ? vid_addr : (cpu_slot ? cpu_addr : '0);
        ram_wdata  = cpu_slot ? cpu_wdata : '0;
        cpu_wait_n = ~reset_n | ~cpu_pend;
        // Read data passes straight through in the ack cycle so the CPU sees it as wait_n rises.
        cpu_rd_ack = cpu_ack_q & ~cpu_ack_we_q & reset_n;
        cpu_rdata  = cpu_rd_ack ? ram_rdata : cpu_rdata_q;
        vid_rvalid = vid_rvalid_q;
        vid_rdata  = ram_rdata;
    end

    // Next-state: one access per armed request, starvation count, response pipeline.
    always_comb begin
        cpu_armed_d  = cpu_armed_q;
        starve_cnt_d = '0;
        cpu_ack_d    = cpu_slot;
        cpu_ack_we_d = cpu_slot & cpu_we;
        vid_rvalid_d = vid_slot;
        cpu_rdata_d  = cpu_rd_ack ? ram_rdata : cpu_rdata_q;
        if (cpu_slot) begin
            cpu_armed_d = 1'b0;
        end else if (!cpu_req) begin
            cpu_armed_d = 1'b1;
        end
        if (vid_slot && cpu_pend) begin
            starve_cnt_d = (starve_cnt_q == MAX_CNT) ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset; in-flight responses are dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cpu_armed_q  <= 1'b1;
            starve_cnt_q <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_ack_we_q <= 1'b0;
            vid_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            cpu_armed_q  <= cpu_armed_d;
            starve_cnt_q <= starve_cnt_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_ack_we_q <= cpu_ack_we_d;
            vid_rvalid_q <= vid_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

endmodule
